// File: rtl/ext_seven_segment_decoder.sv
// Receive-side decoder for the multiplexed external 7-segment bus.
// Deglitches each anode slot, decodes digits and republishes the two-digit score.
module ext_seven_segment_decoder #(
  parameter int STABLE_CNT = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] ext_seg,
  input  logic       ext_an,
  input  logic       err_clr,
  output logic [6:0] score,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       score_valid,
  output logic       blank,
  output logic       pattern_err,
  output logic       stale
);

  // state  | meaning
  // IDLE   | nothing pending
  // HAVE_T | tens slot accepted, waiting for ones
  // HAVE_O | ones slot accepted, waiting for tens
  // PUB    | both slots pending, publish this cycle
  typedef enum logic [1:0] {IDLE, HAVE_T, HAVE_O, PUB} state_t;

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] CODE_BLANK = 4'd10;
  localparam logic [3:0] CODE_ILL   = 4'd15;

  function automatic logic [3:0] decode(input logic [6:0] p);
    case (p)
      7'b0111111: decode = 4'd0;
      7'b0000110: decode = 4'd1;
      7'b1011011: decode = 4'd2;
      7'b1001111: decode = 4'd3;
      7'b1100110: decode = 4'd4;
      7'b1101101: decode = 4'd5;
      7'b1111101: decode = 4'd6;
      7'b0000111: decode = 4'd7;
      7'b1111111: decode = 4'd8;
      7'b1101111: decode = 4'd9;
      7'b0000000: decode = CODE_BLANK;
      default:    decode = CODE_ILL;
    endcase
  endfunction

  state_t          state, state_nxt;
  logic            samp_vld, samp_an;
  logic [6:0]      samp_seg;
  logic [6:0]      last_t, last_o;
  logic [CW-1:0]   cnt_t, cnt_o;
  logic [TW-1:0]   to_cnt;
  logic [3:0]      code;
  logic            hit_t, hit_o, acc_t, acc_o, acc_ill, t_ok, o_ok, to_hit;
  logic            pend_t_blank, pend_o_blank, published;
  logic [3:0]      pend_t_dig, pend_o_dig;
  logic            pub_dig, pub_blank;
  logic [6:0]      new_score;

  // samp_vld keeps the reset value of the sample register from counting as a real sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_vld <= 1'b0;
      samp_an  <= 1'b0;
      samp_seg <= '0;
    end else begin
      samp_vld <= 1'b1;
      samp_an  <= ext_an;
      samp_seg <= ext_seg;
    end
  end

  always_comb begin
    code    = decode(samp_seg);
    hit_t   = samp_vld && samp_an;
    hit_o   = samp_vld && !samp_an;
    acc_t   = hit_t && (samp_seg == last_t) && (cnt_t == CW'(STABLE_CNT - 1));
    acc_o   = hit_o && (samp_seg == last_o) && (cnt_o == CW'(STABLE_CNT - 1));
    acc_ill = (acc_t || acc_o) && (code == CODE_ILL);
    t_ok    = acc_t && (code != CODE_ILL);
    o_ok    = acc_o && (code != CODE_ILL);
    to_hit  = (state != PUB) && (to_cnt == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_t <= '0;
      cnt_t  <= '0;
      last_o <= '0;
      cnt_o  <= '0;
    end else begin
      if (hit_t) begin
        if (samp_seg == last_t) begin
          cnt_t <= acc_t ? '0 : cnt_t + CW'(1);
        end else begin
          last_t <= samp_seg;
          cnt_t  <= CW'(1);
        end
      end
      if (hit_o) begin
        if (samp_seg == last_o) begin
          cnt_o <= acc_o ? '0 : cnt_o + CW'(1);
        end else begin
          last_o <= samp_seg;
          cnt_o  <= CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (t_ok) state_nxt = HAVE_T;
               else if (o_ok) state_nxt = HAVE_O;
      HAVE_T:  if (o_ok) state_nxt = PUB;
      HAVE_O:  if (t_ok) state_nxt = PUB;
      PUB:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (to_hit) state_nxt = IDLE;
  end

  // Blank slots store digit 0 so a mixed blank/digit publish needs no special case
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_t_blank <= 1'b0;
      pend_t_dig   <= '0;
      pend_o_blank <= 1'b0;
      pend_o_dig   <= '0;
    end else if (state == PUB || to_hit) begin
      pend_t_blank <= 1'b0;
      pend_t_dig   <= '0;
      pend_o_blank <= 1'b0;
      pend_o_dig   <= '0;
    end else begin
      if (t_ok) begin
        pend_t_blank <= (code == CODE_BLANK);
        pend_t_dig   <= (code == CODE_BLANK) ? 4'd0 : code;
      end
      if (o_ok) begin
        pend_o_blank <= (code == CODE_BLANK);
        pend_o_dig   <= (code == CODE_BLANK) ? 4'd0 : code;
      end
    end
  end

  always_comb begin
    pub_blank = (state == PUB) && pend_t_blank && pend_o_blank;
    pub_dig   = (state == PUB) && !pub_blank;
    new_score = 7'(pend_t_dig) * 7'd10 + 7'(pend_o_dig);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score       <= '0;
      tens        <= '0;
      ones        <= '0;
      score_valid <= 1'b0;
      blank       <= 1'b0;
      pattern_err <= 1'b0;
      stale       <= 1'b0;
      published   <= 1'b0;
      to_cnt      <= '0;
    end else begin
      score_valid <= pub_dig && (!published || new_score != score);
      if (pub_dig) begin
        score     <= new_score;
        tens      <= pend_t_dig;
        ones      <= pend_o_dig;
        blank     <= 1'b0;
        published <= 1'b1;
      end else if (pub_blank) begin
        blank <= 1'b1;
      end
      if (state == PUB)              to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT)) to_cnt <= to_cnt + TW'(1);
      if (pub_dig)     stale <= 1'b0;
      else if (to_hit) stale <= 1'b1;
      if (acc_ill)      pattern_err <= 1'b1;
      else if (err_clr) pattern_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ext_seven_segment_decoder.sv
// Randomized scoreboard bench for ext_seven_segment_decoder: a slot-level
// model predicts published scores, a monitor checks every score_valid pulse.
module tb_ext_seven_segment_decoder;
  localparam int SC = 4;
  localparam int TO = 1024;

  logic       clk = 1'b0, rst_n = 1'b0, ext_an = 1'b0, err_clr = 1'b0;
  logic [6:0] ext_seg = '0;
  logic [6:0] score;
  logic [3:0] tens, ones;
  logic       score_valid, blank, pattern_err, stale;

  ext_seven_segment_decoder #(.STABLE_CNT(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ext_seg(ext_seg), .ext_an(ext_an), .err_clr(err_clr),
    .score(score), .tens(tens), .ones(ones), .score_valid(score_valid),
    .blank(blank), .pattern_err(pattern_err), .stale(stale)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_ILL   = 7'b1010101;

  typedef struct packed { logic [6:0] s; logic [3:0] t; logic [3:0] o; } exp_t;
  exp_t q[$];

  // reference model: per-slot run lengths, pending digits (-1 none, 10 blank)
  logic [6:0] m_last [2];
  int  m_run [2];
  int  m_pend_t, m_pend_o, m_held, m_ht, m_ho, m_since;
  bit  m_pub_prev, m_published, m_blank, m_err, m_ill_prev, m_stale;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int classify(logic [6:0] p);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
    if (p == SEG_BLANK) return 10;
    return -2;
  endfunction

  task automatic model_reset();
    m_last[0] = '0; m_last[1] = '0; m_run[0] = 0; m_run[1] = 0;
    m_pend_t = -1; m_pend_o = -1; m_held = 0; m_ht = 0; m_ho = 0; m_since = 0;
    m_pub_prev = 0; m_published = 0; m_blank = 0; m_err = 0; m_ill_prev = 0; m_stale = 0;
  endtask

  task automatic model_publish();
    int t, o, s;
    m_pub_prev = 1;
    m_since = 0;
    if (m_pend_t == 10 && m_pend_o == 10) begin
      m_blank = 1;
    end else begin
      t = (m_pend_t == 10) ? 0 : m_pend_t;
      o = (m_pend_o == 10) ? 0 : m_pend_o;
      s = t * 10 + o;
      if (!m_published || s != m_held) q.push_back('{s: 7'(s), t: 4'(t), o: 4'(o)});
      m_held = s; m_ht = t; m_ho = o;
      m_published = 1; m_blank = 0; m_stale = 0;
    end
    m_pend_t = -1; m_pend_o = -1;
  endtask

  task automatic model_step(bit an, logic [6:0] seg, bit clr);
    bit acc, blocked;
    int c;
    m_err = m_ill_prev | (m_err & !clr);
    m_ill_prev = 0;
    m_since++;
    blocked = m_pub_prev;
    m_pub_prev = 0;
    if (m_since == TO + 1) begin
      m_pend_t = -1; m_pend_o = -1; m_stale = 1; blocked = 1;
    end
    acc = 0;
    if (seg == m_last[an]) m_run[an]++;
    else begin m_last[an] = seg; m_run[an] = 1; end
    if (m_run[an] == SC) begin m_run[an] = 0; acc = 1; end
    c = classify(seg);
    if (acc) begin
      if (c == -2) m_ill_prev = 1;
      else if (!blocked) begin
        if (an) m_pend_t = c; else m_pend_o = c;
        if (m_pend_t >= 0 && m_pend_o >= 0) model_publish();
      end
    end
  endtask

  task automatic step(bit an, logic [6:0] seg, bit clr);
    ext_an = an; ext_seg = seg; err_clr = clr;
    @(posedge clk); #1;
    model_step(an, seg, clr);
    chk("pattern_err", int'(pattern_err), int'(m_err));
  endtask

  task automatic alt(logic [6:0] t_seg, logic [6:0] o_seg, int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, t_seg, 1'b0);
      step(1'b0, o_seg, 1'b0);
    end
  endtask

  task automatic checkpoint(string name);
    $display("checkpoint %s score=%0d blank=%0d stale=%0d", name, score, blank, stale);
    chk({name, "_score"}, int'(score), m_held);
    chk({name, "_tens"},  int'(tens),  m_ht);
    chk({name, "_ones"},  int'(ones),  m_ho);
    chk({name, "_blank"}, int'(blank), int'(m_blank));
    chk({name, "_stale"}, int'(stale), int'(m_stale));
    chk({name, "_pulses_outstanding"}, q.size(), 0);
  endtask

  task automatic chk_zero(string name);
    chk({name, "_score"}, int'(score), 0);
    chk({name, "_tens"}, int'(tens), 0);
    chk({name, "_ones"}, int'(ones), 0);
    chk({name, "_valid"}, int'(score_valid), 0);
    chk({name, "_blank"}, int'(blank), 0);
    chk({name, "_err"}, int'(pattern_err), 0);
    chk({name, "_stale"}, int'(stale), 0);
  endtask

  initial begin
    bit found, tog;
    int a, b;
    model_reset();
    fork
      forever begin
        @(negedge clk);
        if (rst_n && score_valid) begin
          exp_t e;
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_pulse actual=%0d expected=no_pulse", score);
          end else begin
            e = q.pop_front();
            chk("pulse_score", int'(score), int'(e.s));
            chk("pulse_tens", int'(tens), int'(e.t));
            chk("pulse_ones", int'(ones), int'(e.o));
          end
        end
      end
    join_none

    #23;
    chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    alt(seg_tab[4], seg_tab[2], 20);
    checkpoint("t1_42");
    alt(seg_tab[4], seg_tab[3], 20);
    checkpoint("t2_43");
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) begin
        step(1'b1, seg_tab[4], 1'b0);
        step(1'b0, (k == 3) ? seg_tab[8] : seg_tab[3], 1'b0);
      end
    end
    checkpoint("t3_glitch");
    alt(SEG_BLANK, SEG_BLANK, 10);
    checkpoint("t4_blank");
    alt(seg_tab[0], seg_tab[7], 10);
    checkpoint("t4_07");

    alt(SEG_ILL, seg_tab[7], 8);
    checkpoint("t5_illegal");
    step(1'b1, SEG_ILL, 1'b1);
    step(1'b0, seg_tab[7], 1'b0);
    found = 0; tog = 1;
    for (int i = 0; i < 40 && !found; i++) begin
      step(tog, tog ? SEG_ILL : seg_tab[7], 1'b0);
      tog = !tog;
      if (m_ill_prev) found = 1;
    end
    chk("illegal_accept_seen", int'(found), 1);
    step(tog, tog ? SEG_ILL : seg_tab[7], 1'b1);
    chk("err_set_wins", int'(pattern_err), 1);
    tog = !tog;
    step(tog, tog ? SEG_ILL : seg_tab[7], 1'b1);
    chk("err_cleared", int'(pattern_err), 0);

    repeat (1100) step(1'b0, seg_tab[5], 1'b0);
    checkpoint("t6_stale");
    alt(seg_tab[6], seg_tab[5], 10);
    checkpoint("t6_resume");

    // randomized two-digit frames
    for (int r = 0; r < 8; r++) begin
      a = $urandom_range(0, 9);
      b = $urandom_range(0, 9);
      alt(seg_tab[a], seg_tab[b], 8 + $urandom_range(0, 4));
    end
    checkpoint("random");

    step(1'b1, seg_tab[6], 1'b0);
    step(1'b0, seg_tab[5], 1'b0);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    q.delete();
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    alt(seg_tab[0], seg_tab[0], 8);
    checkpoint("post_reset_00");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
